risc_boot_ctrl: RTL and testbench

- Synthesizable successor to the bench-level program preload and run control used around the RISC core.
- Accepts a valid/ready word stream and writes it into the instruction memory (IM) or data memory (DM), selected per beat.
- After loading, releases the core from reset, enables it, counts run cycles, and ends on core halt or on a programmable timeout.
- Sits between an external loader (bench, UART bridge) and the core's clock-enable/reset/halt pins and memory write ports.

---
 rtl/risc_boot_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_risc_boot_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : risc_boot_ctrl
// Brief    : Streams a program into IM/DM, releases the RISC core from reset,
//            runs it until halt or timeout. Define RISC_BOOT_CSUM_EN for csum.
// Revision : 1.0 - initial release
// ============================================================================
module risc_boot_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_target,
    input  logic                  ld_last,
    output logic                  im_we,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_rst,
    output logic                  core_en,
    input  logic                  halt,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  ovf,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [ADDR_WIDTH:0]   im_words,
    output logic [ADDR_WIDTH:0]   dm_words,
    output logic [DATA_WIDTH-1:0] csum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH:0]  c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                r_state;
    logic                  r_im_we;
    logic                  r_dm_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_core_rst;
    logic                  r_core_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_ovf;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [ADDR_WIDTH:0]   r_im_words;
    logic [ADDR_WIDTH:0]   r_dm_words;

    logic                  w_start_ok;
    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_TIMEOUT));
    assign w_accept   = ld_valid && (r_state == S_LOAD);
    assign w_cnt_inc  = r_cycle_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_im_we       <= 1'b0;
            r_dm_we       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_core_rst    <= 1'b1;
            r_core_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_ovf         <= 1'b0;
            r_cycle_count <= '0;
            r_im_words    <= '0;
            r_dm_words    <= '0;
        end else begin
            r_im_we <= 1'b0;
            r_dm_we <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_core_rst <= 1'b1;
                r_core_en  <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_timeout  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_TIMEOUT: begin
                        if (w_start_ok) begin
                            r_state       <= S_LOAD;
                            r_core_rst    <= 1'b1;
                            r_core_en     <= 1'b0;
                            r_busy        <= 1'b1;
                            r_done        <= 1'b0;
                            r_timeout     <= 1'b0;
                            r_ovf         <= 1'b0;
                            r_cycle_count <= '0;
                            r_im_words    <= '0;
                            r_dm_words    <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            // A full target still consumes the beat, it just drops the write.
                            if (!ld_target) begin
                                if (r_im_words == c_DEPTH) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_im_we     <= 1'b1;
                                    r_mem_addr  <= r_im_words[ADDR_WIDTH-1:0];
                                    r_mem_wdata <= ld_data;
                                    r_im_words  <= r_im_words + 1'b1;
                                end
                            end else begin
                                if (r_dm_words == c_DEPTH) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_dm_we     <= 1'b1;
                                    r_mem_addr  <= r_dm_words[ADDR_WIDTH-1:0];
                                    r_mem_wdata <= ld_data;
                                    r_dm_words  <= r_dm_words + 1'b1;
                                end
                            end
                            if (ld_last) begin
                                r_state    <= S_RELEASE;
                                r_core_rst <= 1'b0;
                            end
                        end
                    end
                    S_RELEASE: begin
                        r_state   <= S_RUN;
                        r_core_en <= 1'b1;
                    end
                    S_RUN: begin
                        r_cycle_count <= w_cnt_inc;
                        if (halt) begin
                            r_state   <= S_DONE;
                            r_core_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (w_cnt_inc == c_TIMEOUT) begin
                            r_state   <= S_TIMEOUT;
                            r_core_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_core_rst <= 1'b1;
                        r_core_en  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RISC_BOOT_CSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (!abort) begin
            if (w_start_ok) begin
                r_csum <= '0;
            end else if (w_accept) begin
                r_csum <= r_csum + ld_data;
            end
        end
    end

    assign csum = r_csum;
`else
    assign csum = '0;
`endif

    assign ld_ready    = (r_state == S_LOAD);
    assign im_we       = r_im_we;
    assign dm_we       = r_dm_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign core_rst    = r_core_rst;
    assign core_en     = r_core_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign ovf         = r_ovf;
    assign cycle_count = r_cycle_count;
    assign im_words    = r_im_words;
    assign dm_words    = r_dm_words;

endmodule
`default_nettype wire

// File: tb/tb_risc_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_boot_ctrl
// Brief    : Directed and randomized load/run sessions checked against a
//            beat-list reference model. Honours RISC_BOOT_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_boot_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int CW    = 16;
    localparam int TO    = 100;
    localparam int DEPTH = 1 << AW;

`ifdef RISC_BOOT_CSUM_EN
    localparam bit c_CSUM_EN = 1'b1;
`else
    localparam bit c_CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, ld_valid, ld_target, ld_last, halt;
    logic [DW-1:0] ld_data;
    logic          ld_ready, im_we, dm_we, core_rst, core_en;
    logic          busy, done, timeout, ovf;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, csum;
    logic [CW-1:0] cycle_count;
    logic [AW:0]   im_words, dm_words;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [DW-1:0]  q_data[$];
    bit             q_tgt[$];
    logic [DW+AW:0] obs_q[$];

    risc_boot_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_target(ld_target), .ld_last(ld_last),
        .im_we(im_we), .dm_we(dm_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_en(core_en), .halt(halt),
        .busy(busy), .done(done), .timeout(timeout), .ovf(ovf),
        .cycle_count(cycle_count), .im_words(im_words), .dm_words(dm_words),
        .csum(csum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we || dm_we) obs_q.push_back({dm_we, mem_addr, mem_wdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // h = RUN cycle (1-based) in which halt is raised; 0 = never
    task automatic run_session(input int h, input string nm);
        logic [DW+AW:0] exp_q[$];
        logic [DW-1:0]  sum;
        int cim, cdm, i, guard, k, n;
        bit eovf, acc, exp_done;
        int exp_cc;

        cim = 0; cdm = 0; sum = '0; eovf = 1'b0;
        n = q_data.size();
        for (int j = 0; j < n; j++) begin
            sum = sum + q_data[j];
            if (!q_tgt[j]) begin
                if (cim < DEPTH) begin
                    exp_q.push_back({1'b0, AW'(cim), q_data[j]});
                    cim++;
                end else eovf = 1'b1;
            end else begin
                if (cdm < DEPTH) begin
                    exp_q.push_back({1'b1, AW'(cdm), q_data[j]});
                    cdm++;
                end else eovf = 1'b1;
            end
        end
        exp_done = (h >= 1) && (h <= TO);
        exp_cc   = exp_done ? h : TO;

        obs_q.delete();
        pulse_start();
        check({nm, ":load_busy"}, busy, 1);
        check({nm, ":load_core_rst"}, core_rst, 1);
        check({nm, ":load_ready"}, ld_ready, 1);
        check({nm, ":load_cleared"}, {cycle_count, im_words, dm_words, ovf, done, timeout}, 0);
        check({nm, ":load_csum_clr"}, csum, 0);

        i = 0; guard = 0;
        while (i < n && guard < 500) begin
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_data   = q_data[i];
            ld_target = q_tgt[i];
            ld_last   = (i == n - 1);
            acc = ld_valid && ld_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check({nm, ":beats_accepted"}, i, n);

        check({nm, ":rel_core_rst"}, core_rst, 0);
        check({nm, ":rel_core_en"}, core_en, 0);
        check({nm, ":rel_ready"}, ld_ready, 0);
        tick();
        check({nm, ":run_core_en"}, core_en, 1);
        check({nm, ":run_busy"}, busy, 1);

        k = 1;
        while (!done && !timeout && k <= 2 * TO) begin
            halt  = (k == h);
            start = (k == 2);
            tick();
            start = 1'b0;
            k++;
        end
        halt = 1'b0;

        check({nm, ":done"}, done, exp_done);
        check({nm, ":timeout"}, timeout, !exp_done);
        check({nm, ":cycle_count"}, cycle_count, exp_cc);
        check({nm, ":end_core_en"}, core_en, 0);
        check({nm, ":end_core_rst"}, core_rst, 0);
        check({nm, ":end_busy"}, busy, 0);
        check({nm, ":im_words"}, im_words, cim);
        check({nm, ":dm_words"}, dm_words, cdm);
        check({nm, ":ovf"}, ovf, eovf);
        check({nm, ":csum"}, csum, c_CSUM_EN ? sum : '0);
        check({nm, ":n_writes"}, obs_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
            check($sformatf("%s:write%0d", nm, j), obs_q[j], exp_q[j]);

        halt = 1'b1;
        repeat (3) tick();
        halt = 1'b0;
        check({nm, ":frozen_count"}, cycle_count, exp_cc);
        check({nm, ":frozen_state"}, {done, timeout}, {exp_done, !exp_done});
    endtask

    task automatic set_beats(input int n, input logic [DW-1:0] base, input int tmode);
        q_data.delete();
        q_tgt.delete();
        for (int j = 0; j < n; j++) begin
            q_data.push_back(base + DW'(j));
            q_tgt.push_back(tmode == 0 ? 1'b0 : (tmode == 1 ? bit'(j % 2) : bit'($urandom_range(0, 1))));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        ld_target = 1'b0; ld_last = 1'b0; halt = 1'b0; ld_data = '0;
        repeat (3) tick();
        check("reset_core_rst", core_rst, 1);
        check("reset_outputs", {core_en, busy, done, timeout, ovf, ld_ready, im_we, dm_we}, 0);
        check("reset_counters", {cycle_count, im_words, dm_words, mem_addr, mem_wdata}, 0);
        check("reset_csum", csum, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", ld_ready, 0);

        set_beats(3, 32'h0A, 0);
        run_session(5, "t1_im3_halt5");

        set_beats(4, 32'h100, 1);
        run_session(0, "t2_interleave_timeout");

        set_beats(2, 32'h200, 1);
        run_session(TO, "t4_halt_at_limit");

        set_beats(5, 32'h300, 0);
        halt = 1'b1;
        run_session(1, "t5_overflow");

        q_data.delete(); q_tgt.delete();
        q_data.push_back(32'hFFFF_FFFF); q_tgt.push_back(1'b1);
        q_data.push_back(32'h2);         q_tgt.push_back(1'b0);
        run_session(3, "t6_csum_wrap");

        // abort in the middle of a load
        pulse_start();
        ld_valid = 1'b1; ld_data = 32'h55; ld_target = 1'b0; ld_last = 1'b0;
        tick();
        ld_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_core_rst", core_rst, 1);
        check("abort_idle", {busy, ld_ready, core_en}, 0);
        tick();
        check("abort_stays_idle", ld_ready, 0);

        // asynchronous reset in the middle of a run
        pulse_start();
        ld_valid = 1'b1; ld_data = 32'h66; ld_target = 1'b1; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (4) tick();
        check("pre_rst_running", core_en, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_core_rst", core_rst, 1);
        check("async_rst_idle", {core_en, busy, done, timeout}, 0);
        check("async_rst_counters", {cycle_count, im_words, dm_words}, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int s = 0; s < 12; s++) begin
            set_beats($urandom_range(1, 8), $urandom, 2);
            for (int j = 0; j < q_data.size(); j++) q_data[j] = $urandom;
            run_session($urandom_range(0, TO + 10), $sformatf("rand%0d", s));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
